hidden_backprop_neuron: RTL

- Training-direction counterpart of the hidden-layer forward neuron.
- Holds the neuron's 10 weights and drives them to the forward datapath. Given the forward activation and the back-propagated error, it computes the local delta and updates all weights one per cycle.
- Sits between the output-layer error network and the hidden forward neuron. It is controlled by the training sequencer through a start/busy/done handshake.

---
 rtl/nn_fixed_pkg.sv | 40 ++++
 rtl/bp_mul_shift.sv | 25 ++
 rtl/hidden_backprop_neuron.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nn_fixed_pkg.sv
// Fixed-point widths, types, saturation helpers and FSM states for the backprop neuron.
// Pure declarations: no latency, no backpressure.
package nn_fixed_pkg;

  localparam int W_W    = 10;
  localparam int E_W    = 12;
  localparam int VAL_W  = 10;
  localparam int PROD_W = E_W + VAL_W + 1;

  typedef logic signed [W_W-1:0] weight_t;
  typedef logic signed [E_W-1:0] err_t;
  typedef logic        [VAL_W-1:0] val_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DERIV,
    ST_DELTA,
    ST_UPDATE,
    ST_DONE
  } bp_state_t;

  localparam logic signed [E_W:0]    W_MAX_X = (E_W+1)'(2**(W_W-1) - 1);
  localparam logic signed [E_W:0]    W_MIN_X = ~W_MAX_X;
  localparam logic signed [PROD_W-1:0] E_MAX_X = PROD_W'(2**(E_W-1) - 1);
  localparam logic signed [PROD_W-1:0] E_MIN_X = ~E_MAX_X;

  // Weight plus step needs one bit beyond the error width before clamping.
  function automatic weight_t sat_w(input logic signed [E_W:0] v);
    if (v > W_MAX_X)      return W_MAX_X[W_W-1:0];
    else if (v < W_MIN_X) return W_MIN_X[W_W-1:0];
    else                  return v[W_W-1:0];
  endfunction

  function automatic err_t sat_e(input logic signed [PROD_W-1:0] v);
    if (v > E_MAX_X)      return E_MAX_X[E_W-1:0];
    else if (v < E_MIN_X) return E_MIN_X[E_W-1:0];
    else                  return v[E_W-1:0];
  endfunction

endpackage

// File: rtl/bp_mul_shift.sv
// Signed error x unsigned value, arithmetic right shift (floor), saturate to error width.
// Combinational, zero latency; no backpressure.
module bp_mul_shift
  import nn_fixed_pkg::*;
#(
  parameter int SHIFT = 10
) (
  input  err_t i_a,
  input  val_t i_b,
  output err_t o_y
);

  logic signed [PROD_W-1:0] w_a;
  logic signed [PROD_W-1:0] w_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shr;

  // Full-width product is exact, so the only rounding is the floor shift.
  assign w_a    = {{(PROD_W-E_W){i_a[E_W-1]}}, i_a};
  assign w_b    = {{(PROD_W-VAL_W){1'b0}}, i_b};
  assign w_prod = w_a * w_b;
  assign w_shr  = w_prod >>> SHIFT;
  assign o_y    = sat_e(w_shr);

endmodule

// File: rtl/hidden_backprop_neuron.sv
// Hidden-neuron training step: derivative, delta, then one weight update per cycle.
// Latency: done 12 edges after start accept, busy drops one edge later; start/load ignored while busy.
module hidden_backprop_neuron
  import nn_fixed_pkg::*;
#(
  parameter int N_IN     = 10,
  parameter int LR_SHIFT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    weight_load,
  input  weight_t weight_in [N_IN],
  input  logic    start,
  input  val_t    in_val [N_IN],
  input  val_t    out_val,
  input  err_t    err_in,
  output logic    busy,
  output logic    done,
  output err_t    delta_out,
  output weight_t weight_out [N_IN]
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int D_W   = VAL_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  bp_state_t        r_state;
  logic [IDX_W-1:0] r_idx;
  weight_t          r_w [N_IN];
  val_t             r_in [N_IN];
  val_t             r_y;
  err_t             r_err;
  val_t             r_fprime;
  err_t             r_delta;
  logic             r_busy;
  logic             r_done;

  logic signed [D_W-1:0] w_diff;
  logic [VAL_W:0]        w_t;
  logic [VAL_W:0]        w_s;
  logic [2*VAL_W:0]      w_sq;
  val_t                  w_fprime;
  err_t                  w_delta;
  err_t                  w_dw;
  val_t                  w_x;
  weight_t               w_wcur;
  logic signed [E_W:0]   w_sum;

  // f'(y) = 0.5*(1-|2y-1|)^2 in Q0.10: s = 1024-|2y-1024|, fprime = s^2 >> 11
  assign w_diff   = $signed({1'b0, r_y, 1'b0}) - $signed(D_W'(1 << VAL_W));
  assign w_t      = w_diff[D_W-1] ? (VAL_W+1)'(-w_diff) : (VAL_W+1)'(w_diff);
  assign w_s      = (VAL_W+1)'(1 << VAL_W) - w_t;
  assign w_sq     = {{VAL_W{1'b0}}, w_s} * {{VAL_W{1'b0}}, w_s};
  assign w_fprime = VAL_W'(w_sq >> (VAL_W + 1));

  bp_mul_shift #(.SHIFT(10)) u_delta (
    .i_a (r_err),
    .i_b (r_fprime),
    .o_y (w_delta)
  );

  // Two floor shifts compose into one, so grad and learning rate fold together.
  assign w_x    = r_in[r_idx];
  assign w_wcur = r_w[r_idx];

  bp_mul_shift #(.SHIFT(10 + LR_SHIFT)) u_dw (
    .i_a (r_delta),
    .i_b (w_x),
    .o_y (w_dw)
  );

  assign w_sum = {{(E_W+1-W_W){w_wcur[W_W-1]}}, w_wcur} + {w_dw[E_W-1], w_dw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_y      <= '0;
      r_err    <= '0;
      r_fprime <= '0;
      r_delta  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        r_w[i]  <= '0;
        r_in[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (weight_load) begin
            r_w <= weight_in;
          end else if (start) begin
            r_in    <= in_val;
            r_y     <= out_val;
            r_err   <= err_in;
            r_busy  <= 1'b1;
            r_state <= ST_DERIV;
          end
        end
        ST_DERIV: begin
          r_fprime <= w_fprime;
          r_state  <= ST_DELTA;
        end
        ST_DELTA: begin
          r_delta <= w_delta;
          r_idx   <= '0;
          r_state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_w[r_idx] <= sat_w(w_sum);
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign delta_out  = r_delta;
  assign weight_out = r_w;

endmodule
